// File: rtl/multi_cycle_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// multi_cycle_ctrl_pkg
//   Shared definitions for the multi-cycle instruction sequencer:
//   - opcode constants (instruction[30:25])
//   - the eight phase encodings and the number of phases per instruction
//   - the packed strobe vector driven by the sequencer
//   - opcode classification helpers used by the strobe decoder
// -----------------------------------------------------------------------------
package multi_cycle_ctrl_pkg;

  localparam int OPCODE_W = 6;
  localparam int PHASE_W  = 3;

  // Number of phases (clock cycles) spent on every instruction.
  localparam int IR_CYCLE = 8;

  localparam logic [OPCODE_W-1:0] OP_LWI  = 6'b000010;
  localparam logic [OPCODE_W-1:0] OP_SWI  = 6'b001010;
  localparam logic [OPCODE_W-1:0] OP_MOVI = 6'b100010;
  localparam logic [OPCODE_W-1:0] OP_ADDI = 6'b101000;
  localparam logic [OPCODE_W-1:0] OP_ORI  = 6'b101100;
  localparam logic [OPCODE_W-1:0] OP_XORI = 6'b101011;
  localparam logic [OPCODE_W-1:0] OP_ALU  = 6'b100000;

  typedef enum logic [PHASE_W-1:0] {
    PH_FETCH      = 3'd0,
    PH_FETCH_WAIT = 3'd1,
    PH_DECODE     = 3'd2,
    PH_EXEC       = 3'd3,
    PH_MEM        = 3'd4,
    PH_MEM_WAIT   = 3'd5,
    PH_WB         = 3'd6,
    PH_NEXT       = 3'd7
  } phase_e;

  // Strobe bundle; field order is also the bit order of the flat vector.
  typedef struct packed {
    logic im_enable;
    logic im_read;
    logic ir_load;
    logic alu_en;
    logic dm_enable;
    logic dm_read;
    logic dm_write;
    logic reg_write;
    logic wb_sel;
  } strobe_t;

  localparam int      STROBE_W    = 9;
  localparam strobe_t STROBE_IDLE = strobe_t'(9'b0_0000_0000);

  // Classes that use the execute stage.
  function automatic logic is_exec_op(input logic [OPCODE_W-1:0] opcode);
    logic res;
    case (opcode)
      OP_ALU, OP_MOVI, OP_ADDI, OP_ORI, OP_XORI, OP_LWI, OP_SWI: res = 1'b1;
      default:                                                   res = 1'b0;
    endcase
    return res;
  endfunction

  // Classes that write a result back into the register file.
  function automatic logic is_wb_op(input logic [OPCODE_W-1:0] opcode);
    logic res;
    case (opcode)
      OP_ALU, OP_MOVI, OP_ADDI, OP_ORI, OP_XORI, OP_LWI: res = 1'b1;
      default:                                           res = 1'b0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/multi_cycle_ctrl_decode.sv
// -----------------------------------------------------------------------------
// ctrl_decode
//   Purely combinational map from (phase, opcode) to the strobe vector.
//   Ports:
//     phase   in  3  phase the strobes are being computed for
//     opcode  in  6  opcode valid for that phase
//     strobe  out 9  packed strobe_t vector
// -----------------------------------------------------------------------------
module ctrl_decode
  import multi_cycle_ctrl_pkg::*;
(
  input  logic [2:0] phase,
  input  logic [5:0] opcode,
  output logic [8:0] strobe
);

  phase_e  phase_s;
  strobe_t strobe_s;

  assign phase_s = phase_e'(phase);
  assign strobe  = strobe_s;

  // Phase/opcode to strobe decode; anything not named stays idle.
  always_comb begin
    strobe_s = STROBE_IDLE;
    case (phase_s)
      PH_FETCH: begin
        strobe_s.im_enable = 1'b1;
        strobe_s.im_read   = 1'b1;
      end
      PH_FETCH_WAIT: begin
        strobe_s.im_enable = 1'b1;
        strobe_s.im_read   = 1'b1;
        strobe_s.ir_load   = 1'b1;
      end
      PH_DECODE: begin
        strobe_s = STROBE_IDLE;
      end
      PH_EXEC: begin
        strobe_s.alu_en = is_exec_op(opcode);
      end
      PH_MEM: begin
        if (opcode == OP_LWI) begin
          strobe_s.dm_enable = 1'b1;
          strobe_s.dm_read   = 1'b1;
        end else if (opcode == OP_SWI) begin
          // Store is a single-cycle write; no read in the same cycle.
          strobe_s.dm_enable = 1'b1;
          strobe_s.dm_write  = 1'b1;
        end else begin
          strobe_s = STROBE_IDLE;
        end
      end
      PH_MEM_WAIT: begin
        if (opcode == OP_LWI) begin
          strobe_s.dm_enable = 1'b1;
          strobe_s.dm_read   = 1'b1;
        end else begin
          strobe_s = STROBE_IDLE;
        end
      end
      PH_WB: begin
        strobe_s.reg_write = is_wb_op(opcode);
        strobe_s.wb_sel    = (opcode == OP_LWI);
      end
      PH_NEXT: begin
        strobe_s = STROBE_IDLE;
      end
      default: begin
        strobe_s = STROBE_IDLE;
      end
    endcase
  end

endmodule

// File: rtl/multi_cycle_ctrl.sv
// -----------------------------------------------------------------------------
// multi_cycle_ctrl
//   Eight-phase multi-cycle instruction sequencer. Owns the phase counter,
//   PC, latched opcode and the retired-instruction / cycle counters; the
//   strobes come from ctrl_decode and are registered before leaving.
//   Ports:
//     clk          in   1           rising-edge clock
//     rst          in   1           synchronous active-low reset
//     instruction  in   32          IM output word, opcode in [30:25]
//     IM_enable/IM_read/IM_write    out 1 each  instruction-memory controls
//     IM_address   out  IMAddrSize  current PC
//     DM_enable/DM_read/DM_write    out 1 each  data-memory controls
//     ir_load      out  1           instruction-register capture strobe
//     alu_en       out  1           execute-stage enable
//     reg_write    out  1           register-file write strobe
//     wb_sel       out  1           write-back source, 1 = DM_out, 0 = ALU
//     Ins_cnt      out  InsSize     retired instructions
//     Cycle_cnt    out  CycSize     cycles since reset release
// -----------------------------------------------------------------------------
module multi_cycle_ctrl
  import multi_cycle_ctrl_pkg::*;
#(
  parameter int IMAddrSize = 10,
  parameter int InsSize    = 64,
  parameter int CycSize    = 128
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [31:0]           instruction,
  output logic                  IM_enable,
  output logic                  IM_read,
  output logic                  IM_write,
  output logic [IMAddrSize-1:0] IM_address,
  output logic                  DM_enable,
  output logic                  DM_read,
  output logic                  DM_write,
  output logic                  ir_load,
  output logic                  alu_en,
  output logic                  reg_write,
  output logic                  wb_sel,
  output logic [InsSize-1:0]    Ins_cnt,
  output logic [CycSize-1:0]    Cycle_cnt
);

  localparam logic [IMAddrSize-1:0] PC_ONE  = {{(IMAddrSize-1){1'b0}}, 1'b1};
  localparam logic [InsSize-1:0]    INS_ONE = {{(InsSize-1){1'b0}}, 1'b1};
  localparam logic [CycSize-1:0]    CYC_ONE = {{(CycSize-1){1'b0}}, 1'b1};

  // running_r is low for the cycle in which reset is released; the first
  // edge with rst high only arms the sequencer, so phase 0 strobes are
  // already registered when the first real FETCH cycle begins.
  logic                  running_r;
  phase_e                phase_r;
  phase_e                phase_nxt_s;
  logic [5:0]            opcode_r;
  logic [5:0]            opcode_nxt_s;
  logic [IMAddrSize-1:0] pc_r;
  logic [InsSize-1:0]    ins_cnt_r;
  logic [CycSize-1:0]    cyc_cnt_r;
  strobe_t               strobe_r;
  strobe_t               strobe_nxt_s;
  logic                  unused_instr_bits_s;

  assign unused_instr_bits_s = ^{instruction[31], instruction[24:0]};

  // Next phase and next latched opcode; the opcode is captured on the edge
  // that ends FETCH_WAIT so that decode sees it from DECODE onward.
  always_comb begin
    phase_nxt_s  = PH_FETCH;
    opcode_nxt_s = opcode_r;
    if (running_r) begin
      phase_nxt_s = phase_e'(phase_r + 3'd1);
      if (phase_r == PH_FETCH_WAIT) begin
        opcode_nxt_s = instruction[30:25];
      end else begin
        opcode_nxt_s = opcode_r;
      end
    end else begin
      phase_nxt_s  = PH_FETCH;
      opcode_nxt_s = opcode_r;
    end
  end

  // Strobes are decoded for the upcoming phase and then registered, so the
  // outputs line up with phase_r without any combinational path to pins.
  ctrl_decode u_decode (
    .phase  (phase_nxt_s),
    .opcode (opcode_nxt_s),
    .strobe (strobe_nxt_s)
  );

  // Phase register, PC, counters and registered strobes.
  always_ff @(posedge clk) begin
    if (!rst) begin
      running_r <= 1'b0;
      phase_r   <= PH_FETCH;
      opcode_r  <= 6'b000000;
      pc_r      <= {IMAddrSize{1'b0}};
      ins_cnt_r <= {InsSize{1'b0}};
      cyc_cnt_r <= {CycSize{1'b0}};
      strobe_r  <= STROBE_IDLE;
    end else begin
      running_r <= 1'b1;
      phase_r   <= phase_nxt_s;
      opcode_r  <= opcode_nxt_s;
      strobe_r  <= strobe_nxt_s;
      // Counts executed phase cycles, so Cycle_cnt == 8 * Ins_cnt at every
      // instruction boundary.
      if (running_r) begin
        cyc_cnt_r <= cyc_cnt_r + CYC_ONE;
      end else begin
        cyc_cnt_r <= cyc_cnt_r;
      end
      if (running_r && (phase_r == PH_NEXT)) begin
        pc_r      <= pc_r + PC_ONE;
        ins_cnt_r <= ins_cnt_r + INS_ONE;
      end else begin
        pc_r      <= pc_r;
        ins_cnt_r <= ins_cnt_r;
      end
    end
  end

  assign IM_enable  = strobe_r.im_enable;
  assign IM_read    = strobe_r.im_read;
  assign IM_write   = 1'b0;
  assign IM_address = pc_r;
  assign DM_enable  = strobe_r.dm_enable;
  assign DM_read    = strobe_r.dm_read;
  assign DM_write   = strobe_r.dm_write;
  assign ir_load    = strobe_r.ir_load;
  assign alu_en     = strobe_r.alu_en;
  assign reg_write  = strobe_r.reg_write;
  assign wb_sel     = strobe_r.wb_sel;
  assign Ins_cnt    = ins_cnt_r;
  assign Cycle_cnt  = cyc_cnt_r;

endmodule

// File: tb/tb_multi_cycle_ctrl.sv
// -----------------------------------------------------------------------------
// tb_multi_cycle_ctrl
//   Directed, table-driven bench for multi_cycle_ctrl. Each table record holds
//   an opcode and hand-written per-phase masks (bit p = value in phase p) for
//   the opcode-dependent strobes.
// -----------------------------------------------------------------------------
module tb_multi_cycle_ctrl;
  import multi_cycle_ctrl_pkg::*;

  localparam int IMW  = 10;
  localparam int INSW = 64;
  localparam int CYCW = 128;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic [31:0]     instruction = 32'h0000_0000;
  logic            IM_enable, IM_read, IM_write;
  logic [IMW-1:0]  IM_address;
  logic            DM_enable, DM_read, DM_write;
  logic            ir_load, alu_en, reg_write, wb_sel;
  logic [INSW-1:0] Ins_cnt;
  logic [CYCW-1:0] Cycle_cnt;
  logic [8:0]      strobe_vec;

  always #5 clk = ~clk;

  multi_cycle_ctrl #(.IMAddrSize(IMW), .InsSize(INSW), .CycSize(CYCW)) dut (
    .clk(clk), .rst(rst), .instruction(instruction),
    .IM_enable(IM_enable), .IM_read(IM_read), .IM_write(IM_write),
    .IM_address(IM_address),
    .DM_enable(DM_enable), .DM_read(DM_read), .DM_write(DM_write),
    .ir_load(ir_load), .alu_en(alu_en), .reg_write(reg_write), .wb_sel(wb_sel),
    .Ins_cnt(Ins_cnt), .Cycle_cnt(Cycle_cnt)
  );

  // {IM_enable, IM_read, ir_load, alu_en, DM_enable, DM_read, DM_write, reg_write, wb_sel}
  assign strobe_vec = {IM_enable, IM_read, ir_load, alu_en,
                       DM_enable, DM_read, DM_write, reg_write, wb_sel};

  typedef struct {
    logic [5:0] op;
    logic [7:0] alu;
    logic [7:0] dme;
    logic [7:0] dmr;
    logic [7:0] dmw;
    logic [7:0] rw;
    logic [7:0] wb;
  } vec_t;

  localparam int NVEC = 9;
  vec_t tbl [NVEC];

  int checks = 0;
  int errors = 0;
  logic [IMW-1:0]  exp_pc;
  logic [INSW-1:0] exp_ins;
  logic [CYCW-1:0] exp_cyc;

  function automatic vec_t mk(input logic [5:0] op, input logic [7:0] alu,
                              input logic [7:0] dme, input logic [7:0] dmr,
                              input logic [7:0] dmw, input logic [7:0] rw,
                              input logic [7:0] wb);
    vec_t v;
    v.op = op; v.alu = alu; v.dme = dme; v.dmr = dmr;
    v.dmw = dmw; v.rw = rw; v.wb = wb;
    return v;
  endfunction

  function automatic logic [8:0] exp_strobe(input vec_t v, input int p);
    logic [7:0] fetch_m;
    logic [7:0] ir_m;
    logic [2:0] pi;
    fetch_m = 8'h03;
    ir_m    = 8'h02;
    pi      = p[2:0];
    return {fetch_m[pi], fetch_m[pi], ir_m[pi], v.alu[pi],
            v.dme[pi], v.dmr[pi], v.dmw[pi], v.rw[pi], v.wb[pi]};
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Hold reset for two edges, check the reset state, release, and arm.
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_strobes", 128'(strobe_vec), 128'(9'h000));
    check("rst_im_write", 128'(IM_write), 128'(1'b0));
    check("rst_pc", 128'(IM_address), 128'(0));
    check("rst_ins_cnt", 128'(Ins_cnt), 128'(0));
    check("rst_cycle_cnt", 128'(Cycle_cnt), 128'(0));
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    exp_pc  = '0;
    exp_ins = '0;
    exp_cyc = '0;
  endtask

  // Runs one instruction starting just after the edge that begins phase 0.
  // n_ph < 8 stops at the negedge of phase n_ph-1 without advancing.
  task automatic run_instr(input vec_t v, input int n_ph);
    instruction = {1'b1, v.op, 25'h15A_5A5A};
    for (int p = 0; p < IR_CYCLE; p++) begin
      @(negedge clk);
      check("strobes", 128'(strobe_vec), 128'(exp_strobe(v, p)));
      check("cycle_cnt", 128'(Cycle_cnt), 128'(exp_cyc));
      if (p == 0) begin
        check("pc", 128'(IM_address), 128'(exp_pc));
        check("ins_cnt", 128'(Ins_cnt), 128'(exp_ins));
        check("im_write", 128'(IM_write), 128'(1'b0));
      end
      // Opcode must already be latched; scramble the bus afterwards.
      if (p == 2) instruction = ~instruction;
      if ((n_ph < IR_CYCLE) && (p == n_ph - 1)) break;
      @(posedge clk);
      #1;
      exp_cyc++;
      if (p == IR_CYCLE - 1) begin
        exp_pc++;
        exp_ins++;
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = mk(OP_MOVI,  8'h08, 8'h00, 8'h00, 8'h00, 8'h40, 8'h00);
    tbl[1] = mk(OP_ALU,   8'h08, 8'h00, 8'h00, 8'h00, 8'h40, 8'h00);
    tbl[2] = mk(OP_SWI,   8'h08, 8'h10, 8'h00, 8'h10, 8'h00, 8'h00);
    tbl[3] = mk(OP_LWI,   8'h08, 8'h30, 8'h30, 8'h00, 8'h40, 8'h40);
    tbl[4] = mk(OP_ADDI,  8'h08, 8'h00, 8'h00, 8'h00, 8'h40, 8'h00);
    tbl[5] = mk(OP_ORI,   8'h08, 8'h00, 8'h00, 8'h00, 8'h40, 8'h00);
    tbl[6] = mk(OP_XORI,  8'h08, 8'h00, 8'h00, 8'h00, 8'h40, 8'h00);
    tbl[7] = mk(6'b111111, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
    tbl[8] = mk(6'b010101, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);

    // MOVI at PC 0, ALU at 1, SWI at 2, LWI at 3, then the remaining classes.
    do_reset();
    for (int i = 0; i < NVEC; i++) begin
      run_instr(tbl[i], IR_CYCLE);
      if (i == 0) begin
        check("movi_pc", 128'(IM_address), 128'(1));
        check("movi_ins_cnt", 128'(Ins_cnt), 128'(1));
      end
    end
    check("table_pc", 128'(IM_address), 128'(NVEC));

    // 24-instruction program.
    do_reset();
    for (int i = 0; i < 24; i++) run_instr(tbl[i % NVEC], IR_CYCLE);
    check("prog_ins_cnt", 128'(Ins_cnt), 128'(24));
    check("prog_cycle_cnt", 128'(Cycle_cnt), 128'(192));
    check("prog_pc", 128'(IM_address), 128'(24));

    // PC wrap through unrecognised opcodes.
    do_reset();
    for (int i = 0; i < 1023; i++) run_instr(tbl[7 + (i % 2)], IR_CYCLE);
    check("wrap_pre_pc", 128'(IM_address), 128'(1023));
    run_instr(tbl[7], IR_CYCLE);
    check("wrap_pc", 128'(IM_address), 128'(0));
    check("wrap_ins_cnt", 128'(Ins_cnt), 128'(1024));

    // Reset during the MEM phase of a store.
    do_reset();
    run_instr(tbl[0], IR_CYCLE);
    run_instr(tbl[2], 5);
    check("abort_pre_dm_write", 128'(DM_write), 128'(1'b1));
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("abort_dm_write", 128'(DM_write), 128'(1'b0));
    check("abort_strobes", 128'(strobe_vec), 128'(9'h000));
    check("abort_ins_cnt", 128'(Ins_cnt), 128'(0));
    check("abort_cycle_cnt", 128'(Cycle_cnt), 128'(0));
    check("abort_pc", 128'(IM_address), 128'(0));
    @(posedge clk);
    #1;
    check("abort_hold_strobes", 128'(strobe_vec), 128'(9'h000));
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("resume_fetch", 128'(strobe_vec), 128'(9'h180));
    check("resume_cycle_cnt", 128'(Cycle_cnt), 128'(0));
    exp_pc  = '0;
    exp_ins = '0;
    exp_cyc = '0;
    run_instr(tbl[3], IR_CYCLE);
    check("resume_ins_cnt", 128'(Ins_cnt), 128'(1));
    check("resume_pc", 128'(IM_address), 128'(1));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
